mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory-access engine for the CPU data path. It replaces the bare MAR/MDR registers, sign extender and raw MOV/MOC wiring with a self-contained multi-cycle transaction unit. The control unit issues one request and receives a single-cycle completion or error pulse. The unit adds alignment checking, an optional bus-timeout abort and configurable data/address widths.

## Interface
Parameters:
- DATA_W, 32, datapath/word width in bits; must be a multiple of 16, minimum 16
- ADDR_W, 8, memory address width; mem_addr carries the low ADDR_W bits of the latched address
- TIMEOUT, 15, maximum ACCESS cycles without mem_moc before abort (used only with MAU_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  synchronous, active-high reset
- start  in  1  request strobe from control unit, sampled only in IDLE
- r_w  in  1  1 = read, 0 = write
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- se  in  1  sign-extend read data (byte/halfword only)
- addr_in  in  DATA_W  address (ALU output)
- wdata_in  in  DATA_W  write data, right-justified
- mem_rdata  in  DATA_W  memory read data, right-justified
- mem_moc  in  1  memory operation complete
- mem_addr  out  ADDR_W  MAR[ADDR_W-1:0]
- mem_wdata  out  DATA_W  MDR contents
- mem_rw  out  1  latched r_w
- mem_size  out  2  latched size
- mem_mov  out  1  memory operation valid
- rdata  out  DATA_W  extended read result, held until the next read completes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle success pulse
- err  out  1  one-cycle failure pulse

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE with start=1: latch MAR←addr_in, MDR←wdata_in, r_w, size and se.
  - Misaligned (halfword with addr_in[0]=1, word with addr_in[1:0]≠0) or size=11: go to ERR. No bus activity occurs.
  - Otherwise go to ACCESS.
- ACCESS: mem_mov=1; wait counter increments each cycle.
  - mem_moc=1 sampled: on a read, rdata←extend(mem_rdata). Go to DONE.
  - Otherwise stay.
- DONE: done=1, mem_mov=0. Go to IDLE.
- ERR: err=1. Go to IDLE. rdata is unchanged.
- Extension by latched size:
  - byte: bits [7:0]; upper bits = se ? bit 7 : 0
  - halfword: bits [15:0]; upper bits = se ? bit 15 : 0
  - word: pass through unchanged
- start outside IDLE is ignored. A write never alters rdata.
- mem_addr, mem_wdata, mem_rw and mem_size are stable from the first ACCESS cycle until IDLE.

## Timing
- Reset (clr=1 at an edge): state IDLE; MAR, MDR, rdata = 0; mem_rw=1, mem_size=00; mem_mov, busy, done, err = 0; wait counter = 0.
- clr takes priority over all other inputs. If asserted mid-ACCESS, mem_mov drops the following cycle and no done or err pulse is produced.
- start sampled at edge k (aligned request): mem_mov high from cycle k+1. If mem_moc is already high in cycle k+1, done is high in cycle k+2 and busy falls in cycle k+3. Minimum request-to-done latency is 2 cycles.
- Each additional cycle mem_moc stays low adds one cycle of latency.
- Misaligned request at edge k: err high in cycle k+1; mem_mov never asserts.
- Back-to-back: start may be reasserted in the first IDLE cycle after done or err.
- mem_moc outside ACCESS is ignored.

## Configuration
- MAU_TIMEOUT_EN defined:
  - In ACCESS, when the wait counter reaches TIMEOUT with mem_moc still low, go to ERR. mem_mov drops in the err cycle.
  - Counter width is $clog2(TIMEOUT+1). The counter clears on entry to ACCESS.
  - mem_moc and timeout on the same edge: mem_moc wins (DONE).
- MAU_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for mem_moc.

## Test plan
- Reset, then word read, addr_in=0x04, mem_rdata=0x80FF_1234, mem_moc high immediately -> done in cycle k+2, rdata=0x80FF1234, mem_addr=0x04.
- Byte read, se=1, mem_rdata=0x0000_0085 -> rdata=0xFFFFFF85. Same with se=0 -> 0x00000085. Halfword read, se=1, mem_rdata=0x8001 -> 0xFFFF8001.
- Word write, addr_in=0x10, wdata_in=0xDEADBEEF, mem_moc delayed 3 cycles -> mem_mov high 4 cycles, mem_wdata=0xDEADBEEF, done once, rdata unchanged.
- Halfword at addr 0x03, word at 0x02, size=11 -> err pulse one cycle after start, mem_mov stays 0, rdata unchanged.
- clr asserted in second ACCESS cycle -> next cycle mem_mov=0, busy=0, rdata=0, no done/err. A new read then completes normally.
- With MAU_TIMEOUT_EN and TIMEOUT=4, mem_moc held low -> err after 4 ACCESS cycles. Repeat with mem_moc rising on the 4th cycle -> done, no err.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multi-cycle memory-access engine: MAR/MDR latching, alignment check, read-data extension.
// Optional bus-timeout abort enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              r_w,
  input  logic [1:0]        size,
  input  logic              se,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_moc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic              mem_mov,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rw_q, rw_d;
  logic [1:0]          size_q, size_d;
  logic                se_q, se_d;
  logic                mov_q, mov_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                misaligned_c;
  logic [DATA_W-1:0]   ext_c;
  logic                unused_c;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Upper address bits never reach the bus.
  assign unused_c = ^{addr_in[DATA_W-1:ADDR_W], 32'(TIMEOUT)};

  assign misaligned_c = (size == 2'b11) ||
                        ((size == 2'b01) && addr_in[0]) ||
                        ((size == 2'b10) && (addr_in[1:0] != 2'b00));

  // Read-data extension selected by the latched size/se.
  always_comb begin
    ext_c = mem_rdata;
    case (size_q)
      2'b00:   for (int i = 8; i < int'(DATA_W); i++) ext_c[i] = se_q & mem_rdata[7];
      2'b01:   for (int i = 16; i < int'(DATA_W); i++) ext_c[i] = se_q & mem_rdata[15];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    size_d  = size_q;
    se_d    = se_q;
`ifdef MAU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mar_d   = addr_in[ADDR_W-1:0];
          mdr_d   = wdata_in;
          rw_d    = r_w;
          size_d  = size;
          se_d    = se;
          state_d = misaligned_c ? S_ERR : S_ACCESS;
`ifdef MAU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ACCESS: begin
        if (mem_moc) begin
          if (rw_q) rdata_d = ext_c;
          state_d = S_DONE;
        end
`ifdef MAU_TIMEOUT_EN
        // mem_moc has priority over an expiring counter.
        else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mov_d  = (state_d == S_ACCESS);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b1;
      size_q  <= 2'b00;
      se_q    <= 1'b0;
      mov_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      mov_q   <= mov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MAU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_rw    = rw_q;
  assign mem_size  = size_q;
  assign mem_mov   = mov_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an rdata scoreboard.
// Timeout steps run only when MAU_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr, start, r_w, se, mem_moc;
  logic [1:0]  size, mem_size;
  logic [31:0] addr_in, wdata_in, mem_rdata, mem_wdata, rdata;
  logic [7:0]  mem_addr;
  logic        mem_rw, mem_mov, busy, done, err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rdata;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .start(start), .r_w(r_w), .size(size), .se(se),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_rdata(mem_rdata), .mem_moc(mem_moc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_mov(mem_mov), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [1:0] sz, input logic s, input logic [31:0] d);
    case (sz)
      2'b00:   return s ? 32'($signed(d[7:0]))  : {24'h0, d[7:0]};
      2'b01:   return s ? 32'($signed(d[15:0])) : {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // moc_at: ACCESS cycle (1-based) in which mem_moc is raised; 0 = never.
  task automatic run_req(input string name, input logic rw, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int moc_at, input logic exp_err, input int exp_mov, input int exp_end);
    logic [31:0] exp_rd;
    logic [31:0] got;
    int mov_n = 0, done_n = 0, err_n = 0, end_c = 0, fall_c = 0, bad = 0;
    exp_rd = (rw && !exp_err) ? ext_model(sz, s, rd) : model_rdata;
    sb_q.push_back(exp_rd);
    model_rdata = exp_rd;
    r_w = rw; size = sz; se = s; addr_in = a; wdata_in = wd; mem_rdata = rd;
    start = 1'b1; mem_moc = 1'b0;
    tick();
    start = 1'b0;
    addr_in = $urandom; wdata_in = $urandom; r_w = ~rw; size = ~sz; se = ~s;
    for (int c = 1; c <= 60 && fall_c == 0; c++) begin
      if (mem_mov) begin
        mov_n++;
        if (mem_addr !== a[7:0] || mem_wdata !== wd || mem_rw !== rw || mem_size !== sz) bad++;
      end
      if (done) done_n++;
      if (err) err_n++;
      if ((done || err) && end_c == 0) end_c = c;
      if (!busy) fall_c = c;
      mem_moc = mem_mov && (mov_n == moc_at);
      if (fall_c == 0) tick();
    end
    mem_moc = 1'b0;
    chk({name, ":busy_fall"}, 32'(fall_c), 32'(exp_end + 1));
    chk({name, ":end_cycle"}, 32'(end_c), 32'(exp_end));
    chk({name, ":mov_cycles"}, 32'(mov_n), 32'(exp_mov));
    chk({name, ":done_pulses"}, 32'(done_n), exp_err ? 32'd0 : 32'd1);
    chk({name, ":err_pulses"}, 32'(err_n), exp_err ? 32'd1 : 32'd0);
    chk({name, ":bus_stable"}, 32'(bad), 32'd0);
    got = rdata;
    chk({name, ":rdata"}, got, sb_q.pop_front());
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; r_w = 1'b0; size = 2'b00; se = 1'b0;
    addr_in = '0; wdata_in = '0; mem_rdata = '0; mem_moc = 1'b0;
    model_rdata = '0;
    tick(); tick();
    clr = 1'b0;
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done_err", 32'({done, err}), 32'd0);
    chk("rst:mem_mov", 32'(mem_mov), 32'd0);
    chk("rst:mem_rw", 32'(mem_rw), 32'd1);
    chk("rst:mem_size", 32'(mem_size), 32'd0);
    chk("rst:rdata", rdata, 32'd0);
    chk("rst:mar_mdr", {24'h0, mem_addr} | mem_wdata, 32'd0);

    run_req("rd_word",   1'b1, 2'b10, 1'b0, 32'h04, 32'h0,        32'h80FF_1234, 1, 1'b0, 1, 2);
    run_req("rd_byte_s", 1'b1, 2'b00, 1'b1, 32'h21, 32'h0,        32'h1234_5685, 1, 1'b0, 1, 2);
    run_req("rd_byte_u", 1'b1, 2'b00, 1'b0, 32'h23, 32'h0,        32'h0000_0085, 1, 1'b0, 1, 2);
    run_req("rd_half_s", 1'b1, 2'b01, 1'b1, 32'h22, 32'h0,        32'h0000_8001, 1, 1'b0, 1, 2);
    run_req("rd_half_u", 1'b1, 2'b01, 1'b0, 32'h26, 32'h0,        32'hCAFE_8001, 2, 1'b0, 2, 3);
    run_req("wr_word",   1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h1111_1111, 4, 1'b0, 4, 5);
    run_req("mis_half",  1'b1, 2'b01, 1'b1, 32'h03, 32'h0,        32'h5555_5555, 1, 1'b1, 0, 1);
    run_req("mis_word",  1'b1, 2'b10, 1'b0, 32'h02, 32'h0,        32'h6666_6666, 1, 1'b1, 0, 1);
    run_req("rsv_size",  1'b1, 2'b11, 1'b0, 32'h00, 32'h0,        32'h7777_7777, 1, 1'b1, 0, 1);

    // mem_moc while idle must not start anything.
    mem_moc = 1'b1;
    tick(); tick();
    chk("idle_moc:busy", 32'(busy), 32'd0);
    chk("idle_moc:done", 32'(done), 32'd0);
    mem_moc = 1'b0;

    // clr in the second ACCESS cycle aborts silently.
    r_w = 1'b1; size = 2'b10; se = 1'b0; addr_in = 32'h0C; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("clr:mov_before", 32'(mem_mov), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_rdata = '0;
    chk("clr:mem_mov", 32'(mem_mov), 32'd0);
    chk("clr:busy", 32'(busy), 32'd0);
    chk("clr:rdata", rdata, 32'd0);
    chk("clr:done_err", 32'({done, err}), 32'd0);
    tick();
    chk("clr:quiet", 32'({done, err, busy}), 32'd0);

    run_req("rd_after_clr", 1'b1, 2'b10, 1'b0, 32'h08, 32'h0, 32'hA5A5_0F0F, 2, 1'b0, 2, 3);

`ifdef MAU_TIMEOUT_EN
    run_req("timeout",    1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h1357_9BDF, 0, 1'b1, 4, 5);
    run_req("moc_at_lim", 1'b1, 2'b10, 1'b0, 32'h18, 32'h0, 32'h2468_ACE0, 4, 1'b0, 4, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
